// File: rtl/playbus_seq.sv
// playbus_seq: PlayBus controller.
// In IDLE it drives one static source onto the bus. Functions 3..7 run a timed
// source->sink transfer: SETUP -> WRITE -> HOLD -> WAIT_REL.
// Burst mode repeats the transfer over consecutive RAM addresses.
module playbus_seq #(
    parameter int ADDR_W    = 4,
    parameter int SETUP_CYC = 1,
    parameter int WR_CYC    = 1,
    parameter int HOLD_CYC  = 1
) (
    input  logic              CK2HZ,
    input  logic              CLR,
    input  logic              GO,
    input  logic [2:0]        FUNC,
    input  logic [ADDR_W-1:0] ADD,
    input  logic              BURST,
    output logic [ADDR_W-1:0] BUS_ADD,
    output logic              n_ROMO,
    output logic              n_RAMO,
    output logic              n_SWBEN,
    output logic              n_RAMW,
    output logic              LEDLTCH,
    output logic              BUSY,
    output logic              DONE,
    output logic [2:0]        St
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SETUP    = 3'd1,
        WRITE    = 3'd2,
        HOLD     = 3'd3,
        WAIT_REL = 3'd4
    } state_t;

    // Dwell counter only needs to reach the longest phase minus one.
    localparam int MAX_A   = (SETUP_CYC > WR_CYC) ? SETUP_CYC : WR_CYC;
    localparam int MAX_CYC = (MAX_A > HOLD_CYC) ? MAX_A : HOLD_CYC;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0]  SETUP_LAST = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0]  WR_LAST    = CNT_W'(WR_CYC - 1);
    localparam logic [CNT_W-1:0]  HOLD_LAST  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_MAX   = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] ADDR_ONE   = ADDR_W'(1);

    state_t            state_r;
    state_t            state_nx_s;
    logic              go_q_r;
    logic [2:0]        func_q_r;
    logic [ADDR_W-1:0] addr_q_r;
    logic              burst_q_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              n_ramw_r;
    logic              ledltch_r;
    logic              done_r;

    logic              start_s;
    logic              advance_s;
    logic              sink_ram_s;
    logic              sink_led_s;
    logic              src_on_s;
    logic              dwell_s;

    // Next-state decode: start detection, phase dwell and burst continuation.
    always_comb begin
        state_nx_s = state_r;
        start_s    = 1'b0;
        advance_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (GO && !go_q_r && (FUNC >= 3'd3)) begin
                    start_s    = 1'b1;
                    state_nx_s = SETUP;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            SETUP: begin
                if (cnt_r == SETUP_LAST) begin
                    state_nx_s = WRITE;
                end else begin
                    state_nx_s = SETUP;
                end
            end
            WRITE: begin
                if (cnt_r == WR_LAST) begin
                    state_nx_s = HOLD;
                end else begin
                    state_nx_s = WRITE;
                end
            end
            HOLD: begin
                if (cnt_r == HOLD_LAST) begin
                    // Burst stops after the top address; never wraps to zero.
                    if (burst_q_r && (addr_q_r != ADDR_MAX)) begin
                        advance_s  = 1'b1;
                        state_nx_s = SETUP;
                    end else begin
                        state_nx_s = WAIT_REL;
                    end
                end else begin
                    state_nx_s = HOLD;
                end
            end
            WAIT_REL: begin
                if (!GO) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = WAIT_REL;
                end
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // Sink selection from the latched function.
    always_comb begin
        sink_ram_s = (func_q_r == 3'd3) || (func_q_r == 3'd4);
        sink_led_s = (func_q_r == 3'd5) || (func_q_r == 3'd6) || (func_q_r == 3'd7);
        src_on_s   = (state_r == SETUP) || (state_r == WRITE) || (state_r == HOLD);
        dwell_s    = (state_nx_s == state_r) && src_on_s;
    end

    // Sequencer state, latched request, dwell counter and registered strobes.
    always_ff @(posedge CK2HZ or posedge CLR) begin
        if (CLR) begin
            state_r   <= IDLE;
            go_q_r    <= 1'b0;
            func_q_r  <= 3'd0;
            addr_q_r  <= '0;
            burst_q_r <= 1'b0;
            cnt_r     <= '0;
            n_ramw_r  <= 1'b1;
            ledltch_r <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            go_q_r  <= GO;
            if (dwell_s) begin
                cnt_r <= cnt_r + CNT_ONE;
            end else begin
                cnt_r <= '0;
            end
            if (start_s) begin
                func_q_r  <= FUNC;
                addr_q_r  <= ADD;
                burst_q_r <= BURST & ((FUNC == 3'd3) || (FUNC == 3'd4));
            end else if (advance_s) begin
                addr_q_r  <= addr_q_r + ADDR_ONE;
            end else begin
                addr_q_r  <= addr_q_r;
            end
            // Strobes follow the next state so they move with St.
            n_ramw_r  <= !((state_nx_s == WRITE) && sink_ram_s);
            ledltch_r <= (state_nx_s == WRITE) && sink_led_s;
            done_r    <= (state_r == HOLD) && (state_nx_s == WAIT_REL);
        end
    end

    // Source enables and bus address: static in IDLE, latched while busy.
    always_comb begin
        n_ROMO  = 1'b1;
        n_RAMO  = 1'b1;
        n_SWBEN = 1'b1;
        if (state_r == IDLE) begin
            BUS_ADD = ADD;
            case (FUNC)
                3'd0:    n_ROMO  = 1'b0;
                3'd1:    n_RAMO  = 1'b0;
                3'd2:    n_SWBEN = 1'b0;
                default: n_ROMO  = 1'b1;
            endcase
        end else begin
            BUS_ADD = addr_q_r;
            if (src_on_s) begin
                case (func_q_r)
                    3'd3, 3'd5: n_SWBEN = 1'b0;
                    3'd4, 3'd6: n_ROMO  = 1'b0;
                    3'd7:       n_RAMO  = 1'b0;
                    default:    n_ROMO  = 1'b1;
                endcase
            end else begin
                n_ROMO = 1'b1;
            end
        end
    end

    assign n_RAMW  = n_ramw_r;
    assign LEDLTCH = ledltch_r;
    assign DONE    = done_r;
    assign BUSY    = (state_r != IDLE);
    assign St      = state_r;

endmodule
